dmem_line_responder: RTL and testbench

DMEM_LINE_RESPONDER -- requirements
Module: dmem_line_responder

---
 rtl/dmem_line_responder.sv | 96 +++++++++
 tb/tb_dmem_line_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_line_responder.sv
// Fixed-latency 256-bit line store answering one cache refill/write-back at a time.
// Ack arrives LATENCY cycles after accept; no new request is taken while busy_o is high.
module dmem_line_responder #(
   parameter int LATENCY    = 10,
   parameter int DEPTH_LOG2 = 9
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         enable_i,
   input  logic         write_i,
   input  logic [31:0]  addr_i,
   input  logic [255:0] data_i,
   output logic         ack_o,
   output logic [255:0] data_o,
   output logic         busy_o
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;
   localparam int         DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [7:0] CNT_LAST = 8'(LATENCY - 1);

   logic [1:0]            state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  wr_q, wr_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic [255:0]          wdat_q, wdat_d;
   logic                  ack_q, ack_d;
   logic [255:0]          rdat_q, rdat_d;
   logic [255:0]          mem_q [DEPTH];
   logic                  enter_ack;
   logic                  unused_addr;

   assign unused_addr = ^{addr_i[31:DEPTH_LOG2+5], addr_i[4:0]};

   // The accept edge is edge 0, so the counter reads LATENCY-1 on the edge that enters ACK.
   assign enter_ack = (state_q == BUSY) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      idx_d   = idx_q;
      wdat_d  = wdat_q;
      case (state_q)
         IDLE: begin
            if (enable_i) begin
               state_d = BUSY;
               cnt_d   = 8'd0;
               wr_d    = write_i;
               idx_d   = addr_i[DEPTH_LOG2+4:5];
               wdat_d  = data_i;
            end
         end
         BUSY: begin
            cnt_d = cnt_q + 8'd1;
            if (enter_ack) state_d = ACK;
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      ack_d  = (state_d == ACK);
      rdat_d = (enter_ack && !wr_q) ? mem_q[idx_q] : rdat_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         wdat_q  <= '0;
         ack_q   <= 1'b0;
         rdat_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         idx_q   <= idx_d;
         wdat_q  <= wdat_d;
         ack_q   <= ack_d;
         rdat_q  <= rdat_d;
      end
   end

   // Array is never cleared; a reset edge landing on the commit edge drops the write.
   always_ff @(posedge clk_i) begin
      if (!rst_i && enter_ack && wr_q) mem_q[idx_q] <= wdat_q;
   end

   assign ack_o  = ack_q;
   assign data_o = rdat_q;
   assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder: reference line model plus a queue of expected refill data.
module tb_dmem_line_responder;

   localparam int LAT = 10;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         enable_i;
   logic         write_i;
   logic [31:0]  addr_i;
   logic [255:0] data_i;
   logic         ack_o;
   logic [255:0] data_o;
   logic         busy_o;

   int checks = 0;
   int errors = 0;
   int ack_seen = 0;

   logic [255:0] model [int];
   logic [255:0] exp_q [$];

   dmem_line_responder #(.LATENCY(LAT), .DEPTH_LOG2(9)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .enable_i (enable_i),
      .write_i  (write_i),
      .addr_i   (addr_i),
      .data_i   (data_i),
      .ack_o    (ack_o),
      .data_o   (data_o),
      .busy_o   (busy_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) if (ack_o === 1'b1) ack_seen++;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int line_of(input logic [31:0] a);
      return int'((a >> 5) & 32'd511);
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Waits for ack after an accept edge; returns the number of edges taken (999 on timeout).
   task automatic wait_ack(input bit scramble, output int n);
      bit got = 1'b0;
      n = 0;
      while (n < 300 && !got) begin
         if (scramble) begin
            enable_i = 1'($urandom);
            write_i  = 1'($urandom);
            addr_i   = $urandom;
            data_i   = rnd256();
         end
         @(posedge clk_i); #1;
         n++;
         if (ack_o === 1'b1) got = 1'b1;
      end
      enable_i = 1'b0;
      if (!got) n = 999;
   endtask

   task automatic req(input string tag, input logic wr, input logic [31:0] a,
                      input logic [255:0] d, input bit scramble);
      int n;
      logic [255:0] exp_rd;
      logic [255:0] prev_do;
      @(negedge clk_i);
      enable_i = 1'b1;
      write_i  = wr;
      addr_i   = a;
      data_i   = d;
      prev_do  = data_o;
      if (wr) model[line_of(a)] = d;
      else    exp_q.push_back(model[line_of(a)]);
      @(posedge clk_i); #1;
      check({tag, ".accept_busy"}, 256'(busy_o), 256'(1));
      enable_i = 1'b0;
      wait_ack(scramble, n);
      check({tag, ".latency"}, 256'(n), 256'(LAT));
      check({tag, ".busy_in_ack"}, 256'(busy_o), 256'(1));
      if (!wr) begin
         exp_rd = exp_q.pop_front();
         check({tag, ".rdata"}, data_o, exp_rd);
      end else begin
         exp_rd = prev_do;
         check({tag, ".wr_keeps_dout"}, data_o, prev_do);
      end
      @(posedge clk_i); #1;
      check({tag, ".ack_one_cycle"}, 256'(ack_o), 256'(0));
      check({tag, ".idle_after_ack"}, 256'(busy_o), 256'(0));
      if (!wr) check({tag, ".rdata_hold"}, data_o, exp_rd);
   endtask

   initial begin
      logic [255:0] pat_a5, pat_11, pat_al, pat_bb, pat_mid, pat_old, pat_new, pat_l3;
      int base, n;
      pat_a5 = {32{8'hA5}};
      pat_11 = {32{8'h11}};
      pat_al = rnd256();
      pat_bb = rnd256();
      pat_mid = rnd256();
      pat_old = {32{8'h3C}};
      pat_new = {32{8'hC3}};

      rst_i = 1'b1; enable_i = 1'b0; write_i = 1'b0; addr_i = '0; data_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      check("reset.ack", 256'(ack_o), 256'(0));
      check("reset.busy", 256'(busy_o), 256'(0));
      check("reset.dout", data_o, 256'(0));
      @(negedge clk_i); rst_i = 1'b0;

      // Refill timing on line 3 after preloading it.
      req("preload3", 1'b1, 32'h0000_0060, pat_a5, 1'b0);
      base = ack_seen;
      req("refill3", 1'b0, 32'h0000_0060, '0, 1'b0);
      check("refill3.acks", 256'(ack_seen - base), 256'(1));

      // Write then read the same line.
      base = ack_seen;
      req("wr40", 1'b1, 32'h0000_0040, pat_11, 1'b0);
      req("rd40", 1'b0, 32'h0000_0040, '0, 1'b0);
      check("wr_rd.acks", 256'(ack_seen - base), 256'(2));

      // Aliasing above the index field.
      req("wr4020", 1'b1, 32'h0000_4020, pat_al, 1'b0);
      req("rd0020", 1'b0, 32'h0000_0020, '0, 1'b0);

      // Back-to-back write-back then refill with enable held high.
      base = ack_seen;
      @(negedge clk_i);
      enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h0000_0400; data_i = pat_bb;
      model[line_of(32'h400)] = pat_bb;
      @(posedge clk_i); #1;
      n = 0;
      while (n < 300 && ack_o !== 1'b1) begin
         @(posedge clk_i); #1;
         n++;
      end
      check("b2b.wb_latency", 256'(n), 256'(LAT));
      write_i = 1'b0; addr_i = 32'h0000_0020;
      exp_q.push_back(model[line_of(32'h20)]);
      @(posedge clk_i); #1;
      check("b2b.ack_not_req_busy", 256'(busy_o), 256'(0));
      @(posedge clk_i); #1;
      check("b2b.second_accept", 256'(busy_o), 256'(1));
      enable_i = 1'b0;
      wait_ack(1'b0, n);
      check("b2b.rf_latency", 256'(n), 256'(LAT));
      check("b2b.rdata", data_o, exp_q.pop_front());
      repeat (20) @(posedge clk_i);
      #1;
      check("b2b.acks", 256'(ack_seen - base), 256'(2));
      check("b2b.idle", 256'(busy_o), 256'(0));

      // Inputs scrambled while busy must not disturb the captured request.
      req("mid_wr", 1'b1, 32'h0000_00A0, pat_mid, 1'b1);
      req("mid_rd", 1'b0, 32'h0000_00A0, '0, 1'b1);
      pat_l3 = model[3];
      req("mid_l3", 1'b0, 32'h0000_0060, '0, 1'b0);
      req("mid_l32", 1'b0, 32'h0000_0400, '0, 1'b0);
      check("mid.l3_model", model[3], pat_l3);

      // Reset five cycles into a write to line 7.
      req("pre7", 1'b1, 32'h0000_00E0, pat_old, 1'b0);
      req("rd3_nz", 1'b0, 32'h0000_0060, '0, 1'b0);
      base = ack_seen;
      @(negedge clk_i);
      enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h0000_00E0; data_i = pat_new;
      @(posedge clk_i); #1;
      enable_i = 1'b0;
      repeat (5) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      #1;
      check("rst_busy.ack", 256'(ack_o), 256'(0));
      check("rst_busy.busy", 256'(busy_o), 256'(0));
      check("rst_busy.dout", data_o, 256'(0));
      repeat (LAT + 2) @(posedge clk_i);
      @(negedge clk_i); rst_i = 1'b0;
      check("rst_busy.no_ack", 256'(ack_seen - base), 256'(0));
      req("rd7", 1'b0, 32'h0000_00E0, '0, 1'b0);

      check("queue_empty", 256'(exp_q.size()), 256'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
